// File: rtl/pid_multichannel.sv
`default_nettype none
// ============================================================================
// Module      : pid_multichannel
// Description : Time-multiplexed PID controller for N_CH channels. A periodic
//               tick starts a sweep that walks the channels in ascending order
//               through a single shared signed multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module pid_multichannel #(
    parameter int N_CH   = 4,
    parameter int DW     = 16,
    parameter int FRAC   = 8,
    parameter int PERIOD = 1_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH-1:0]    enable,
    input  logic [N_CH*DW-1:0] setpoint,
    input  logic [N_CH*DW-1:0] feedback,
    input  logic [N_CH-1:0]    feedback_valid,
    input  logic [N_CH*DW-1:0] kp,
    input  logic [N_CH*DW-1:0] ki,
    input  logic [N_CH*DW-1:0] kd,
    input  logic [DW-1:0]      max_output,
    output logic [N_CH*DW-1:0] pid_output,
    output logic [N_CH-1:0]    output_valid,
    output logic               busy,
    output logic               overrun
);
    localparam int CW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int EW  = DW + 1;         // error / feedback-delta width
    localparam int PW  = 2 * EW;         // full product width
    localparam int AW  = DW + FRAC + 1;  // integral accumulator width
    localparam int SW  = PW + 2;         // summation headroom
    localparam logic [CW-1:0]  C_CNT_LAST = CW'(PERIOD - 1);
    localparam logic [CHW-1:0] C_CH_LAST  = CHW'(N_CH - 1);

    typedef enum logic [2:0] {IDLE, LOAD, MUL_P, MUL_I, MUL_D, SUM, WRITE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [CHW-1:0]       ch_q;
    logic                 overrun_q;
    logic [N_CH-1:0]      valid_q;
    logic [N_CH-1:0]      prime_q;
    logic signed [AW-1:0] acc_q [N_CH];
    logic signed [DW-1:0] fbp_q [N_CH];
    logic signed [DW-1:0] out_q [N_CH];

    // Working registers of the channel currently being computed
    logic signed [DW-1:0] sp_q, fb_q, res_q;
    logic signed [EW-1:0] e_q, dfb_q;
    logic [DW-1:0]        kp_q, ki_q, kd_q, max_q;
    logic signed [PW-1:0] p_q, d_q;
    logic signed [AW-1:0] accn_q;

    logic                 w_tick, w_last, w_run;
    logic signed [DW-1:0] w_sp, w_fb;
    logic [DW-1:0]        w_mul_a, w_lim_out;
    logic signed [EW-1:0] w_mul_b;
    logic signed [PW-1:0] w_prod;
    logic signed [SW-1:0] w_acc_sum, w_acc_lim, w_acc_sat, w_total, w_shift, w_out_lim;
    logic signed [DW-1:0] w_res;

    assign w_tick = (cnt_q == C_CNT_LAST);
    assign w_last = (ch_q == C_CH_LAST);
    assign w_run  = enable[ch_q] & feedback_valid[ch_q];
    assign w_sp   = $signed(setpoint[ch_q*DW +: DW]);
    assign w_fb   = $signed(feedback[ch_q*DW +: DW]);

    // Free-running control-tick counter
    always_ff @(posedge clk) begin
        if (rst)         cnt_q <= '0;
        else if (w_tick) cnt_q <= '0;
        else             cnt_q <= cnt_q + CW'(1);
    end

    // Sweep state register and sticky overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_tick && (state_q != IDLE)) overrun_q <= 1'b1;
        end
    end

    // Sweep next-state logic; disabled or invalid channels are skipped in LOAD
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_tick) state_d = LOAD;
            LOAD:    state_d = w_run ? MUL_P : (w_last ? IDLE : LOAD);
            MUL_P:   state_d = MUL_I;
            MUL_I:   state_d = MUL_D;
            MUL_D:   state_d = SUM;
            SUM:     state_d = WRITE;
            WRITE:   state_d = w_last ? IDLE : LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Shared multiplier operand select: gain is zero-extended, product kept full width
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (state_q)
            MUL_P:   begin w_mul_a = kp_q; w_mul_b = e_q;   end
            MUL_I:   begin w_mul_a = ki_q; w_mul_b = e_q;   end
            MUL_D:   begin w_mul_a = kd_q; w_mul_b = dfb_q; end
            default: ;
        endcase
    end
    assign w_prod = $signed({1'b0, w_mul_a}) * w_mul_b;

    // Integral update clamped to +/-(max_output << FRAC); output sum, shift and saturate
    always_comb begin
        w_acc_sum = acc_q[ch_q] + w_prod;
        w_acc_lim = $signed(SW'(max_q) << FRAC);
        if (w_acc_sum > w_acc_lim)       w_acc_sat = w_acc_lim;
        else if (w_acc_sum < -w_acc_lim) w_acc_sat = -w_acc_lim;
        else                             w_acc_sat = w_acc_sum;
        w_total   = p_q + accn_q + d_q;
        w_shift   = w_total >>> FRAC;
        // the output is signed DW, so the limit cannot exceed its positive range
        w_lim_out = max_q[DW-1] ? {1'b0, {(DW-1){1'b1}}} : max_q;
        w_out_lim = $signed(SW'(w_lim_out));
        w_res     = w_shift[DW-1:0];
        if (w_shift > w_out_lim)       w_res = $signed(w_lim_out);
        else if (w_shift < -w_out_lim) w_res = -$signed(w_lim_out);
    end

    // Per-computation datapath and channel pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q <= '0; sp_q <= '0; fb_q <= '0; e_q <= '0; dfb_q <= '0;
            kp_q <= '0; ki_q <= '0; kd_q <= '0; max_q <= '0;
            p_q <= '0; d_q <= '0; accn_q <= '0; res_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (w_tick) ch_q <= '0;
                LOAD: begin
                    if (w_run) begin
                        sp_q  <= w_sp;
                        fb_q  <= w_fb;
                        e_q   <= {w_sp[DW-1], w_sp} - {w_fb[DW-1], w_fb};
                        dfb_q <= {w_fb[DW-1], w_fb} - {fbp_q[ch_q][DW-1], fbp_q[ch_q]};
                        kp_q  <= kp[ch_q*DW +: DW];
                        ki_q  <= ki[ch_q*DW +: DW];
                        kd_q  <= kd[ch_q*DW +: DW];
                        max_q <= max_output;
                    end else if (!w_last) begin
                        ch_q <= ch_q + CHW'(1);
                    end
                end
                MUL_P:   p_q    <= w_prod;
                MUL_I:   accn_q <= w_acc_sat[AW-1:0];
                MUL_D:   d_q    <= prime_q[ch_q] ? -w_prod : '0;
                SUM:     res_q  <= w_res;
                WRITE:   if (!w_last) ch_q <= ch_q + CHW'(1);
                default: ;
            endcase
        end
    end

    // Per-channel state: cleared while disabled, committed in WRITE if still enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            prime_q <= '0;
            for (int c = 0; c < N_CH; c++) begin
                acc_q[c] <= '0;
                fbp_q[c] <= '0;
                out_q[c] <= '0;
            end
        end else begin
            valid_q <= '0;
            for (int c = 0; c < N_CH; c++) begin
                if (!enable[c]) begin
                    acc_q[c]   <= '0;
                    prime_q[c] <= 1'b0;
                    out_q[c]   <= '0;
                end
            end
            if ((state_q == WRITE) && enable[ch_q]) begin
                valid_q[ch_q] <= 1'b1;
                fbp_q[ch_q]   <= fb_q;
                if (sp_q == '0) begin
                    out_q[ch_q]   <= '0;
                    acc_q[ch_q]   <= '0;
                    prime_q[ch_q] <= 1'b0;
                end else begin
                    out_q[ch_q]   <= res_q;
                    acc_q[ch_q]   <= accn_q;
                    prime_q[ch_q] <= 1'b1;
                end
            end
        end
    end

    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_out
            assign pid_output[c*DW +: DW] = out_q[c];
        end
    endgenerate

    assign output_valid = valid_q;
    assign busy         = (state_q != IDLE);
    assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: doc/pid_multichannel.md
PID_MULTICHANNEL -- requirements
Module: pid_multichannel

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of independent PID channels (1..16).
REQ-002 The block SHALL have parameter DW, default 16, giving the signed width of setpoint, feedback and output.
REQ-003 The block SHALL have parameter FRAC, default 8, giving the number of fractional bits in every unsigned gain.
REQ-004 The block SHALL have parameter PERIOD, default 1_000_000, giving the control-tick period in clk cycles.
REQ-005 The block SHALL have the following ports, with bus channel c at bits [c*DW +: DW]:
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  N_CH  per-channel PID enable
- setpoint  in  N_CH*DW  signed target per channel
- feedback  in  N_CH*DW  signed measurement per channel
- feedback_valid  in  N_CH  per-channel measurement-valid qualifier
- kp, ki, kd  in  N_CH*DW each  unsigned gains, scaled by 2^FRAC
- max_output  in  DW  unsigned saturation limit, shared by all channels
- pid_output  out  N_CH*DW  signed registered output per channel
- output_valid  out  N_CH  one-cycle pulse per channel update
- busy  out  1  high while a sweep is in progress
- overrun  out  1  sticky: a tick arrived while busy

Function
REQ-006 The tick counter SHALL count 0..PERIOD-1 and wrap, asserting an internal tick for one cycle at count PERIOD-1.
REQ-007 If tick occurs while idle, the block SHALL start a sweep over channels 0..N_CH-1 in ascending order; if tick occurs while busy, the tick SHALL be dropped and overrun set until rst.
REQ-008 The sweep FSM SHALL use states IDLE, LOAD, MUL_P, MUL_I, MUL_D, SUM, WRITE, with exactly one shared signed multiplier used in MUL_P, MUL_I and MUL_D only.
REQ-009 In LOAD, a channel with enable=0 or feedback_valid=0 SHALL be skipped: next channel on the following cycle, its state and output untouched, and no output_valid pulse.
REQ-010 A computed channel SHALL take 6 cycles, LOAD through WRITE; pid_output and output_valid[c] SHALL update on the WRITE-cycle edge; busy SHALL drop and the FSM return to IDLE after the last channel.
REQ-011 Setpoint and feedback SHALL be sampled once, in LOAD, and held for that channel's computation.
REQ-012 Error e SHALL be the DW+1-bit signed value setpoint - feedback; gains SHALL be zero-extended; products SHALL be kept at full width without truncation.
REQ-013 The integral accumulator acc SHALL update as acc + ki*e and be clamped to +/-(max_output << FRAC), stored unshifted.
REQ-014 The derivative SHALL act on measurement: D = -kd*(feedback - fb_prev); D SHALL be 0 on the first computation after enable rises or after reset (prime flag); fb_prev SHALL be updated in WRITE.
REQ-015 In SUM, the output SHALL be (kp*e + acc + D) >>> FRAC, arithmetic shift, saturated to [-max_output, +max_output]; max_output=0 SHALL force output 0.
REQ-016 If the sampled setpoint is 0, the channel SHALL write output 0, clear acc, clear the prime flag and still pulse output_valid.
REQ-017 While enable[c]=0, acc, prime flag and pid_output for channel c SHALL be cleared on every clock; if enable drops mid-computation of c, the WRITE SHALL be suppressed.
REQ-018 Changes to gains and max_output SHALL take effect from the next LOAD; there SHALL be no other configuration latching.

Reset
REQ-019 While rst=1: pid_output=0, output_valid=0, busy=0, overrun=0, every acc=0, every fb_prev=0, every prime flag clear, tick counter=0, FSM=IDLE.
REQ-020 After rst is released, the first tick SHALL occur PERIOD cycles later; rst asserted mid-sweep SHALL abort the sweep without any output_valid pulse.

Verification (N_CH=4, DW=16, FRAC=8, PERIOD=64, max_output=1000 unless stated)
REQ-021 rst, then ch0 kp=256, ki=kd=0, sp=100, fb=40, enable[0]=1 -> pid_output[0]=60 with output_valid[0] pulsing 6 cycles after tick; other channels stay 0 with no pulse.
REQ-022 Saturation: ch1 kp=25600, sp=100, fb=0 -> output 1000; with sp=-100 -> output -1000; with max_output=0 -> output 0.
REQ-023 Integral: ch2 ki=256, kp=0, sp=10, fb=0 -> outputs 10, 20, 30 on successive ticks, then hold at 1000; change fb to 20 -> next output 990 (no windup lag).
REQ-024 Derivative: ch3 kd=256, sp=500, fb=0 -> first output 0 (primed); fb steps to 50 -> output -50; drop enable[3] -> pid_output[3]=0 on the next cycle.
REQ-025 Sweep timing: PERIOD=20 with all 4 channels computing (24 cycles) -> overrun=1; with channels 1-3 disabled -> sweep takes 9 cycles and overrun stays 0.
